// File: rtl/oven_ctrl_fsm.sv
// Oven controller: button edge detection, ON/OFF and setting FSM, simulated
// preheat/bake/cool-down thermal model, MM:SS uptime and four-digit BCD display.
module oven_ctrl_fsm #(
  parameter int TICK_DIV  = 25000000,
  parameter int TEMP_W    = 11,
  parameter int TEMP_MIN  = 150,
  parameter int TEMP_MAX  = 550,
  parameter int TEMP_DEF  = 350,
  parameter int TEMP_STEP = 25,
  parameter int AMBIENT   = 70,
  parameter int HEAT_RATE = 5,
  parameter int COOL_RATE = 2,
  parameter int TOL       = 5,
  parameter int TIME_STEP = 60,
  parameter int MAX_TIME  = 5940
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_power,
  input  logic              btn_mode,
  input  logic              btn_up,
  input  logic              btn_down,
  input  logic              btn_start,
  output logic              heater,
  output logic              done,
  output logic [2:0]        state,
  output logic [TEMP_W-1:0] temp,
  output logic [3:0]        dig3,
  output logic [3:0]        dig2,
  output logic [3:0]        dig1,
  output logic [3:0]        dig0
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int BT_W  = $clog2(MAX_TIME + 1);

  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [TEMP_W-1:0] T_MIN    = TEMP_W'(TEMP_MIN);
  localparam logic [TEMP_W-1:0] T_MAX    = TEMP_W'(TEMP_MAX);
  localparam logic [TEMP_W-1:0] T_DEF    = TEMP_W'(TEMP_DEF);
  localparam logic [TEMP_W-1:0] T_STEP   = TEMP_W'(TEMP_STEP);
  localparam logic [TEMP_W-1:0] T_AMB    = TEMP_W'(AMBIENT);
  localparam logic [TEMP_W-1:0] T_HEAT   = TEMP_W'(HEAT_RATE);
  localparam logic [TEMP_W-1:0] T_COOL   = TEMP_W'(COOL_RATE);
  localparam logic [TEMP_W-1:0] T_TOL    = TEMP_W'(TOL);
  localparam logic [BT_W-1:0]   B_MAX    = BT_W'(MAX_TIME);
  localparam logic [BT_W-1:0]   B_STEP   = BT_W'(TIME_STEP);
  localparam logic [BT_W-1:0]   B_ONE    = BT_W'(1);
  localparam logic [BT_W-1:0]   B_ZERO   = {BT_W{1'b0}};

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_SET_TEMP = 3'd1,
    S_SET_TIME = 3'd2,
    S_PREHEAT  = 3'd3,
    S_BAKE     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  function automatic logic [15:0] bcd4(input logic [13:0] v);
    logic [15:0] r;
    r[15:12] = 4'((v / 14'd1000) % 14'd10);
    r[11:8]  = 4'((v / 14'd100) % 14'd10);
    r[7:4]   = 4'((v / 14'd10) % 14'd10);
    r[3:0]   = 4'(v % 14'd10);
    return r;
  endfunction

  function automatic logic [15:0] mmss(input logic [13:0] t);
    logic [13:0] m;
    logic [13:0] s;
    m = t / 14'd60;
    s = t % 14'd60;
    return {4'((m / 14'd10) % 14'd10), 4'(m % 14'd10), 4'(s / 14'd10), 4'(s % 14'd10)};
  endfunction

  // BCD MM:SS increment, 99:59 rolls over to 00:00
  function automatic logic [15:0] upt_inc(input logic [15:0] u);
    logic [15:0] r;
    r = u;
    if (u[3:0] != 4'd9) begin
      r[3:0] = u[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (u[7:4] != 4'd5) begin
        r[7:4] = u[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (u[11:8] != 4'd9) begin
          r[11:8] = u[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = (u[15:12] != 4'd9) ? u[15:12] + 4'd1 : 4'd0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [TEMP_W-1:0] heat(input logic [TEMP_W-1:0] t,
                                             input logic [TEMP_W-1:0] tgt);
    logic [TEMP_W:0] s;
    s = {1'b0, t} + {1'b0, T_HEAT};
    if (s >= {1'b0, tgt}) return tgt;
    else return s[TEMP_W-1:0];
  endfunction

  function automatic logic [TEMP_W-1:0] cool(input logic [TEMP_W-1:0] t);
    if (t > T_AMB + T_COOL) return t - T_COOL;
    else return T_AMB;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        sync1_q, sync2_q, prev_q;
  logic [TEMP_W-1:0] target_q, target_d;
  logic [TEMP_W-1:0] temp_q, temp_d;
  logic [BT_W-1:0]   bake_q, bake_d;
  logic [15:0]       upt_q, upt_d;
  logic [15:0]       dig_q, dig_d;
  logic              heater_q, heater_d;
  logic              done_q, done_d;

  logic              tick;
  logic [4:0]        rise;
  logic              act_pw, act_st, act_md, act_up, act_dn;
  logic [TEMP_W-1:0] thr;

  // {power, start, mode, up, down}; one action per cycle in priority order
  assign rise   = sync2_q & ~prev_q;
  assign act_pw = rise[4];
  assign act_st = rise[3] & ~rise[4];
  assign act_md = rise[2] & ~rise[3] & ~rise[4];
  assign act_up = rise[1] & ~rise[0] & ~(|rise[4:2]);
  assign act_dn = rise[0] & ~rise[1] & ~(|rise[4:2]);
  assign tick   = (cnt_q == CNT_LAST);
  assign thr    = (target_q > T_TOL) ? target_q - T_TOL : {TEMP_W{1'b0}};

  // state, datapath and registered-output flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OFF;
      cnt_q    <= {CNT_W{1'b0}};
      sync1_q  <= 5'd0;
      sync2_q  <= 5'd0;
      prev_q   <= 5'd0;
      target_q <= T_DEF;
      temp_q   <= T_AMB;
      bake_q   <= B_ZERO;
      upt_q    <= 16'h0000;
      dig_q    <= 16'h0000;
      heater_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sync1_q  <= {btn_power, btn_start, btn_mode, btn_up, btn_down};
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      target_q <= target_d;
      temp_q   <= temp_d;
      bake_q   <= bake_d;
      upt_q    <= upt_d;
      dig_q    <= dig_d;
      heater_q <= heater_d;
      done_q   <= done_d;
    end
  end

  // next state, settings, thermal model and timers
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    bake_d   = bake_q;
    temp_d   = temp_q;
    cnt_d    = tick ? {CNT_W{1'b0}} : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    upt_d    = tick ? upt_inc(upt_q) : upt_q;
    case (state_q)
      S_OFF: begin
        if (act_pw) state_d = S_SET_TEMP;
        else state_d = S_OFF;
      end
      S_SET_TEMP, S_SET_TIME: begin
        if (act_pw) begin
          state_d = S_OFF;
        end else if (act_st) begin
          if (bake_q != B_ZERO) state_d = S_PREHEAT;
          else state_d = state_q;
        end else if (act_md) begin
          state_d = (state_q == S_SET_TEMP) ? S_SET_TIME : S_SET_TEMP;
        end else if (state_q == S_SET_TEMP) begin
          if (act_up) target_d = (target_q >= T_MAX - T_STEP) ? T_MAX : target_q + T_STEP;
          else if (act_dn) target_d = (target_q <= T_MIN + T_STEP) ? T_MIN : target_q - T_STEP;
          else target_d = target_q;
        end else begin
          if (act_up) bake_d = (bake_q >= B_MAX - B_STEP) ? B_MAX : bake_q + B_STEP;
          else if (act_dn) bake_d = (bake_q <= B_STEP) ? B_ZERO : bake_q - B_STEP;
          else bake_d = bake_q;
        end
      end
      S_PREHEAT: begin
        if (act_pw) state_d = S_OFF;
        else if (temp_q >= thr) state_d = S_BAKE;
        else state_d = S_PREHEAT;
      end
      S_BAKE: begin
        if (act_pw) state_d = S_OFF;
        else if (tick && bake_q == B_ONE) state_d = S_DONE;
        else state_d = S_BAKE;
      end
      S_DONE: begin
        if (act_pw) state_d = S_OFF;
        else if (act_st || act_md) state_d = S_SET_TEMP;
        else state_d = S_DONE;
      end
      default: state_d = S_OFF;
    endcase
    if (tick) begin
      case (state_q)
        S_PREHEAT: temp_d = heat(temp_q, target_q);
        S_BAKE: begin
          temp_d = (temp_q < target_q) ? heat(temp_q, target_q) : temp_q;
          bake_d = (bake_q == B_ZERO) ? B_ZERO : bake_q - B_ONE;
        end
        default: temp_d = cool(temp_q);
      endcase
    end else begin
      temp_d = temp_q;
    end
  end

  // output decode: heater/done follow the next state, digits follow current values
  always_comb begin
    heater_d = (state_d == S_PREHEAT) || ((state_d == S_BAKE) && (temp_d < target_d));
    done_d   = (state_d == S_DONE);
    case (state_q)
      S_OFF:      dig_d = upt_q;
      S_SET_TEMP: dig_d = bcd4(14'(target_q));
      S_SET_TIME: dig_d = mmss(14'(bake_q));
      S_PREHEAT:  dig_d = bcd4(14'(temp_q));
      S_BAKE:     dig_d = mmss(14'(bake_q));
      S_DONE:     dig_d = 16'h0000;
      default:    dig_d = 16'h0000;
    endcase
  end

  assign state  = state_q;
  assign temp   = temp_q;
  assign heater = heater_q;
  assign done   = done_q;
  assign dig3   = dig_q[15:12];
  assign dig2   = dig_q[11:8];
  assign dig1   = dig_q[7:4];
  assign dig0   = dig_q[3:0];

endmodule

// File: tb/tb_oven_ctrl_fsm.sv
// Directed bench for oven_ctrl_fsm with TICK_DIV=4; expected values hand-computed.
module tb_oven_ctrl_fsm;

  localparam int B_PWR = 4;
  localparam int B_ST  = 3;
  localparam int B_MD  = 2;
  localparam int B_UP  = 1;
  localparam int B_DN  = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btn;
  logic        heater, done;
  logic [2:0]  state;
  logic [10:0] temp;
  logic [3:0]  dig3, dig2, dig1, dig0;
  logic [15:0] digs;
  int          checks = 0;
  int          errors = 0;

  assign digs = {dig3, dig2, dig1, dig0};

  always #5 clk = ~clk;

  oven_ctrl_fsm #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst),
    .btn_power(btn[B_PWR]), .btn_mode(btn[B_MD]), .btn_up(btn[B_UP]),
    .btn_down(btn[B_DN]), .btn_start(btn[B_ST]),
    .heater(heater), .done(done), .state(state), .temp(temp),
    .dig3(dig3), .dig2(dig2), .dig1(dig1), .dig0(dig0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    @(negedge clk);
    btn = 5'd0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(state), 32'(s));
  endtask

  initial begin
    rst = 1'b1;
    btn = 5'd0;
    repeat (2) @(negedge clk);
    check("rst_state", 32'(state), 32'd0);
    check("rst_temp", 32'(temp), 32'd70);
    check("rst_digits", 32'(digs), 32'h0000);
    check("rst_heater", 32'(heater), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("uptime_0002", 32'(digs), 32'h0002);

    press(B_PWR);
    check("on_state", 32'(state), 32'd1);
    check("on_target_def", 32'(digs), 32'h0350);
    check("on_temp_ambient", 32'(temp), 32'd70);

    for (int i = 0; i < 9; i++) press(B_UP);
    check("target_sat_max", 32'(digs), 32'h0550);
    for (int i = 0; i < 20; i++) press(B_DN);
    check("target_sat_min", 32'(digs), 32'h0150);

    btn = 5'b00011;
    @(negedge clk);
    btn = 5'd0;
    repeat (4) @(negedge clk);
    check("updown_nochange", 32'(digs), 32'h0150);
    check("updown_state", 32'(state), 32'd1);

    press(B_ST);
    check("start_zero_settemp", 32'(state), 32'd1);
    press(B_MD);
    check("mode_settime", 32'(state), 32'd2);
    check("settime_digits0", 32'(digs), 32'h0000);
    press(B_ST);
    check("start_zero_settime", 32'(state), 32'd2);

    btn[B_UP] = 1'b1;
    repeat (10) @(negedge clk);
    btn = 5'd0;
    repeat (4) @(negedge clk);
    check("held_up_once", 32'(digs), 32'h0100);

    press(B_ST);
    check("preheat_state", 32'(state), 32'd3);
    check("preheat_heater", 32'(heater), 32'd1);
    wait_state(3'd4, 200, "reach_bake");
    check("bake_entry_temp", 32'(temp), 32'd145);
    check("bake_entry_heater", 32'(heater), 32'd1);
    check("preheat_shows_temp", 32'(digs), 32'h0145);
    @(negedge clk);
    check("bake_shows_time", 32'(digs), 32'h0100);

    wait_state(3'd5, 300, "reach_done");
    check("done_flag", 32'(done), 32'd1);
    check("done_heater", 32'(heater), 32'd0);
    check("done_temp", 32'(temp), 32'd150);
    @(negedge clk);
    check("done_digits", 32'(digs), 32'h0000);

    press(B_ST);
    check("ack_state", 32'(state), 32'd1);
    check("ack_done", 32'(done), 32'd0);

    repeat (80) @(negedge clk);
    press(B_MD);
    press(B_UP);
    press(B_ST);
    wait_state(3'd4, 200, "reach_bake2");
    @(negedge clk);
    press(B_PWR);
    check("power_off_state", 32'(state), 32'd0);
    check("power_off_heater", 32'(heater), 32'd0);
    press(B_PWR);
    check("target_retained", 32'(digs), 32'h0150);
    press(B_MD);
    check("bake_retained", 32'(digs), 32'h0059);

    press(B_ST);
    check("preheat2_state", 32'(state), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_temp", 32'(temp), 32'd70);
    check("midrst_digits", 32'(digs), 32'h0000);
    check("midrst_heater", 32'(heater), 32'd0);
    rst = 1'b0;
    press(B_PWR);
    check("midrst_target_def", 32'(digs), 32'h0350);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
